// File: rtl/hs_unit_rr_arb_reg.sv
// Round-robin arbiter over NUM_REQ valid/ready producers
// feeding one shared output register with requester index.
module hs_unit_rr_arb_reg #(
  parameter type DATA_TYPE = logic,
  parameter int  NUM_REQ   = 4,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  DATA_TYPE             req_data [NUM_REQ],
  output logic                 out_valid,
  input  logic                 out_ready,
  output DATA_TYPE             out_data,
  output logic [IDX_W-1:0]     out_idx
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   g;
  logic [IDX_W-1:0]   g_hi;
  logic [IDX_W-1:0]   g_lo;
  logic [IDX_W-1:0]   ptr_nxt;
  logic               hi;
  logic               lo;
  logic               found;
  logic               load;
  logic               xfer;
  logic [NUM_REQ-1:0] grant;

  // Requesters at/above the pointer beat those that wrapped below it.
  always_comb begin
    hi   = 1'b0;
    lo   = 1'b0;
    g_hi = '0;
    g_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDX_W'(i) >= rr_ptr) begin
          hi   = 1'b1;
          g_hi = IDX_W'(i);
        end else begin
          lo   = 1'b1;
          g_lo = IDX_W'(i);
        end
      end
    end
    found = hi || lo;
    g     = hi ? g_hi : g_lo;
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = found && (IDX_W'(i) == g);
    end
  end

  assign load      = !out_valid || out_ready;
  assign xfer      = load && found && !rst;
  assign req_ready = (load && !rst) ? grant : '0;
  assign ptr_nxt   = (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_idx <= g;
        rr_ptr  <= ptr_nxt;
      end
    end
  end

  // Datapath register, intentionally not reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      out_data <= req_data[g];
    end
  end

endmodule

// File: tb/tb_hs_unit_rr_arb_reg.sv
// Scoreboard bench for hs_unit_rr_arb_reg, NUM_REQ=4,
// 8-bit payload.
module tb_hs_unit_rr_arb_reg;

  typedef logic [7:0] data_t;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  data_t      req_data [4];
  logic       out_valid;
  logic       out_ready;
  data_t      out_data;
  logic [1:0] out_idx;

  int vec;
  int fails;

  int         m_ptr;
  logic       m_valid;
  logic [9:0] cur;
  logic [9:0] exp_q [$];

  hs_unit_rr_arb_reg #(
    .DATA_TYPE(data_t),
    .NUM_REQ  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of stimulus against the reference arbiter model.
  task automatic cycle(input logic [3:0] v, input logic ordy);
    logic       load;
    logic       found;
    int         g;
    logic [3:0] er;
    req_valid = v;
    out_ready = ordy;
    #1;
    load  = !m_valid || ordy;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (!found && v[j]) begin
        found = 1'b1;
        g     = j;
      end
    end
    er = (load && found) ? 4'(1 << g) : 4'b0;
    vec++;
    if (req_ready !== er) begin
      fails++;
      $display("FAIL req_ready got %b exp %b", req_ready, er);
    end
    if (load && found) exp_q.push_back({2'(g), req_data[g]});
    @(posedge clk);
    #1;
    if (load) begin
      m_valid = found;
      if (found) begin
        m_ptr = (g + 1) % 4;
        cur   = exp_q.pop_front();
      end
    end
    vec++;
    if (out_valid !== m_valid) begin
      fails++;
      $display("FAIL out_valid got %b exp %b", out_valid, m_valid);
    end
    if (m_valid) begin
      vec++;
      if ({out_idx, out_data} !== cur) begin
        fails++;
        $display("FAIL beat got %h/%h exp %h/%h",
                 out_idx, out_data, cur[9:8], cur[7:0]);
      end
    end
    vec++;
    if (dut.rr_ptr !== 2'(m_ptr)) begin
      fails++;
      $display("FAIL rr_ptr got %0d exp %0d", dut.rr_ptr, m_ptr);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'hf;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = data_t'(8'h11 * i);
    #1;
    repeat (2) begin
      vec++;
      if (req_ready !== 4'b0) begin
        fails++;
        $display("FAIL rst_ready got %b exp 0000", req_ready);
      end
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    req_valid = 4'b0;
    vec++;
    if (out_valid !== 1'b0 || out_idx !== 2'd0) begin
      fails++;
      $display("FAIL rst_state got v=%b i=%0d exp v=0 i=0",
               out_valid, out_idx);
    end
    m_ptr   = 0;
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_rotation();
    logic [1:0] seq [5];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 5; k++) begin
      cycle(4'hf, 1'b1);
      vec++;
      if (out_valid !== 1'b1 || out_idx !== seq[k] ||
          out_data !== data_t'(8'h11 * seq[k])) begin
        fails++;
        $display("FAIL rotation[%0d] got %b/%0d/%h exp 1/%0d/%h",
                 k, out_valid, out_idx, out_data, seq[k],
                 8'h11 * seq[k]);
      end
    end
  endtask

  task automatic test_skip();
    logic [1:0] seq [3];
    seq = '{2'd3, 2'd0, 2'd3};
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1001, 1'b1);
      vec++;
      if (out_idx !== seq[k] ||
          (out_valid && (out_idx == 2'd1 || out_idx == 2'd2))) begin
        fails++;
        $display("FAIL skip[%0d] got %0d exp %0d", k, out_idx, seq[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    req_data[2] = 8'hA5;
    cycle(4'b0100, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1000, 1'b0);
      vec++;
      if (out_data !== 8'hA5 || out_idx !== 2'd2 ||
          dut.rr_ptr !== 2'd3) begin
        fails++;
        $display("FAIL stall[%0d] got %h/%0d/%0d exp a5/2/3",
                 k, out_data, out_idx, dut.rr_ptr);
      end
    end
    cycle(4'b1000, 1'b1);
    vec++;
    if (out_idx !== 2'd3 || out_data !== 8'h33) begin
      fails++;
      $display("FAIL release got %0d/%h exp 3/33", out_idx, out_data);
    end
  endtask

  task automatic test_empty_drain();
    cycle(4'b0001, 1'b1);
    cycle(4'b0000, 1'b1);
    vec++;
    if (out_valid !== 1'b0 || dut.rr_ptr !== 2'd1) begin
      fails++;
      $display("FAIL drain got v=%b p=%0d exp v=0 p=1",
               out_valid, dut.rr_ptr);
    end
  endtask

  task automatic test_reset_mid();
    cycle(4'b0010, 1'b1);
    cycle(4'b0000, 1'b0);
    rst       = 1'b1;
    req_valid = 4'hf;
    #1;
    vec++;
    if (req_ready !== 4'b0) begin
      fails++;
      $display("FAIL mid_rst_ready got %b exp 0000", req_ready);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0;
    vec++;
    if (out_valid !== 1'b0 || dut.rr_ptr !== 2'd0) begin
      fails++;
      $display("FAIL mid_rst got v=%b p=%0d exp v=0 p=0",
               out_valid, dut.rr_ptr);
    end
    m_ptr   = 0;
    m_valid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      cycle(4'b0000, 1'b1);
      vec++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL held_beat got v=%b exp v=0", out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 4; i++) req_data[i] = data_t'($urandom);
      cycle(4'($urandom), 1'($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    vec       = 0;
    fails     = 0;
    rst       = 1'b1;
    req_valid = 4'b0;
    out_ready = 1'b0;
    m_ptr     = 0;
    m_valid   = 1'b0;
    cur       = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_rotation();
    test_skip();
    test_backpressure();
    test_empty_drain();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule

// File: doc/hs_unit_rr_arb_reg.md
Name: hs_unit_rr_arb_reg

Overview:
- N-way round-robin arbiter feeding a single shared output pipeline register.
- Multiple valid/ready producers share one registered datapath stage.
- One winner per cycle is captured into the output register, together with its requester index.
- Generic DATA_TYPE payload.
- Sits in front of shared downstream resources (buses, single-port units) wherever several requesters contend for one register stage.

Parameters:
- DATA_TYPE, logic: payload type; any packed type.
- NUM_REQ, 4: number of requesters; legal range 1..16.
- IDX_W (localparam), max(1, $clog2(NUM_REQ)): width of the requester index.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  [NUM_REQ-1:0]  per-requester valid.
- req_ready  output  [NUM_REQ-1:0]  per-requester ready; at most one bit high per cycle.
- req_data  input  DATA_TYPE [NUM_REQ-1:0]  per-requester payload (unpacked array).
- out_valid  output  1  output register holds a valid beat.
- out_ready  input  1  downstream accepts a beat.
- out_data  output  DATA_TYPE  registered payload.
- out_idx  output  IDX_W  registered index of the requester that produced out_data.

Behaviour:
- Reset: one clock, synchronous, active-high (rst); no asynchronous paths.
- Reset values:
  - out_valid=0, out_idx=0, rr_ptr=0.
  - out_data is NOT reset (datapath register, no reset); its value is don't-care while out_valid=0.
- Load condition: load = !out_valid || out_ready (output register empty, or being drained this cycle).
- Grant is combinational:
  - Search req_valid starting at rr_ptr, ascending with wrap at NUM_REQ-1 -> 0.
  - First set bit is the winner g.
  - grant one-hot; grant=0 when req_valid=0.
- Requester handshake:
  - req_ready[i] = load && grant[i].
  - A transfer from requester i occurs when req_valid[i] && req_ready[i].
  - req_ready may depend combinationally on req_valid and out_ready. Requesters must not make req_valid depend on req_ready.
- On a transfer from g at posedge:
  - out_data <= req_data[g]; out_idx <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- On load with no req_valid: out_valid <= 0 if out_ready drained the beat; rr_ptr unchanged.
- Stall (out_valid && !out_ready): all req_ready=0; out_data/out_idx/out_valid held stable; rr_ptr held.
- Simultaneous drain and refill (out_valid && out_ready && a req valid) gives full throughput: new beat registered, out_valid stays 1.
- Latency: accepted beat appears on out_* the cycle after the transfer. Throughput is 1 beat/cycle.
- Fairness:
  - A continuously asserted requester is granted within NUM_REQ transfers.
  - With all requesters valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- NUM_REQ=1: rr_ptr is constant 0, out_idx=0; degenerates to a single valid/ready register slice.
- Reset mid-operation: any held beat is discarded.
  - out_valid=0 and rr_ptr=0 the cycle after rst.
  - req_ready=0 while rst=1 (no transfer may occur during reset).
- Requesters must hold req_valid/req_data stable until accepted; the block does not check this.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0 throughout; out_valid=0, out_idx=0 after reset.
- Rotation (NUM_REQ=4, DATA_TYPE=logic[7:0]):
  - Stimulus: req_valid=4'b1111, req_data={8'h33,8'h22,8'h11,8'h00}, out_ready=1 constantly.
  - Expected: out_idx sequence 0,1,2,3,0 on consecutive cycles; out_data 00,11,22,33,00.
  - out_valid stays 1 from the first beat onward.
- Skip idle requesters:
  - Stimulus: rr_ptr=1, req_valid=4'b1001.
  - Expected: grant 3, then (ptr=0) grant 0, then (ptr=1) grant 3.
  - No cycle with out_valid=1 and out_idx 1 or 2.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with beat 8'hA5/idx 2 held.
  - Expected: out_data=A5 and out_idx=2 stable; req_ready=0; rr_ptr=3 unchanged.
  - Release out_ready=1 -> requester 3 (if valid) granted the same cycle; its beat is on out_* the next cycle.
- Empty drain: single beat accepted, then req_valid=0 with out_ready=1 -> out_valid falls to 0 one cycle after the beat; rr_ptr unchanged.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, rr_ptr=0, and the held beat is never presented.
